// File: rtl/mygo_arb_pkg.sv
// mygo_arb_pkg: shared arbitration types and limits for channel sender merging
package mygo_arb_pkg;
  typedef enum logic [0:0] {ARB_IDLE, ARB_LOCKED} arb_state_t;
  localparam int ARB_MAX_SENDERS = 16;
endpackage

// File: rtl/mygo_rr_pick.sv
// mygo_rr_pick: combinational round-robin pick of the first request after last
module mygo_rr_pick #(
  parameter int N = 4,
  parameter int IDX_BITS = $clog2(N)
) (
  input  logic [N-1:0]        req,
  input  logic [IDX_BITS-1:0] last,
  output logic                any,
  output logic [IDX_BITS-1:0] idx
);
  always_comb begin
    any = |req;
    idx = '0;
    // Walk offsets from farthest to nearest so the nearest request after last wins.
    for (int k = N; k >= 1; k--)
      if (req[(int'(last) + k) % N]) idx = IDX_BITS'((int'(last) + k) % N);
  end
endmodule

// File: rtl/mygo_chan_arb.sv
// mygo_chan_arb: round-robin merge of N sender streams with burst locking into one registered port
module mygo_chan_arb
  import mygo_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N = 4,
  parameter int MAX_BURST = 8,
  parameter int IDX_BITS = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   s_data,
  input  logic [N-1:0]         s_valid,
  input  logic [N-1:0]         s_lock,
  output logic [N-1:0]         s_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [IDX_BITS-1:0]  m_src
);
  localparam int BW = $clog2(MAX_BURST + 1);
  arb_state_t state, state_nx;
  logic [BW-1:0] burst, burst_nx;
  logic [IDX_BITS-1:0] last, pick, win;
  logic any, win_valid, fire, go_lock, done;
  mygo_rr_pick #(.N(N), .IDX_BITS(IDX_BITS)) u_pick (
    .req(s_valid),
    .last(last),
    .any(any),
    .idx(pick)
  );
  // While locked only the owner can win, so last always holds the owner index.
  assign win = state == ARB_LOCKED ? last : pick;
  assign win_valid = state == ARB_LOCKED ? s_valid[last] : any;
  assign fire = rst & (!m_valid | m_ready) & win_valid;
  assign s_ready = fire ? N'(1) << win : '0;
  assign go_lock = s_lock[win] && MAX_BURST > 1;
  assign done = !s_lock[win] || burst == BW'(MAX_BURST - 1);
  always_comb begin
    state_nx = !fire ? state : state == ARB_IDLE ? (go_lock ? ARB_LOCKED : ARB_IDLE) : (done ? ARB_IDLE : ARB_LOCKED);
    burst_nx = state_nx == ARB_LOCKED ? (fire ? burst + 1'b1 : burst) : '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= ARB_IDLE;
      burst <= '0;
    end else begin
      state <= state_nx;
      burst <= burst_nx;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      m_valid <= 1'b0;
      m_data <= '0;
      m_src <= '0;
      last <= IDX_BITS'(N - 1);
    end else if (fire) begin
      m_valid <= 1'b1;
      m_data <= s_data[int'(win)*WIDTH +: WIDTH];
      m_src <= win;
      last <= win;
    end else if (m_ready) m_valid <= 1'b0;
endmodule

// File: tb/tb_mygo_chan_arb.sv
// tb_mygo_chan_arb: directed scoreboard bench for the channel sender arbiter
module tb_mygo_chan_arb;
  localparam int W = 32;
  localparam int N = 4;
  localparam int IB = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N*W-1:0] s_data;
  logic [N-1:0] s_valid, s_lock, s_ready;
  logic [W-1:0] m_data;
  logic m_valid, m_ready;
  logic [IB-1:0] m_src;
  int n_cmp = 0;
  int n_bad = 0;
  int cnt[N] = '{default: 0};
  int exp_cnt[N] = '{default: 0};
  typedef struct {int src; logic [W-1:0] data;} beat_t;
  beat_t q[$];

  mygo_chan_arb #(.WIDTH(W), .N(N), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_lock(s_lock),
    .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_src(m_src)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] dat(int i, int n);
    return {i[7:0], n[23:0]};
  endfunction

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(int s);
    q.push_back('{src: s, data: dat(s, exp_cnt[s])});
    exp_cnt[s]++;
  endtask

  task automatic drive(logic [N-1:0] v, logic [N-1:0] l, logic mr);
    s_valid = v;
    s_lock = l;
    m_ready = mr;
    for (int i = 0; i < N; i++) s_data[i*W +: W] = dat(i, cnt[i]);
  endtask

  task automatic cyc(logic [N-1:0] v, logic [N-1:0] l, logic mr, logic [N-1:0] er);
    logic [N-1:0] hs;
    drive(v, l, mr);
    @(negedge clk);
    check("s_ready", W'(s_ready), W'(er));
    hs = s_valid & s_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs[i]) cnt[i]++;
  endtask

  always @(negedge clk)
    if (rst && m_valid && m_ready) begin
      beat_t e;
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL beat_unexpected: got src %0d data %h expected no beat", m_src, m_data);
      end else begin
        e = q.pop_front();
        if (m_src !== IB'(e.src) || m_data !== e.data) begin
          n_bad++;
          $display("FAIL beat: got src %0d data %h expected src %0d data %h", m_src, m_data, e.src, e.data);
        end
      end
    end

  initial begin
    drive(4'b1111, 4'b0000, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", W'(m_valid), 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_src", W'(m_src), 0);
    check("rst_s_ready", W'(s_ready), 0);
    rst = 1'b1;
    for (int k = 0; k < 8; k++) push(k % 4);
    for (int k = 0; k < 8; k++) cyc(4'b1111, 4'b0000, 1'b1, 4'(1) << (k % 4));
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000);
    push(0);
    push(1);
    cyc(4'b1111, 4'b0000, 1'b1, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      cyc(4'b1111, 4'b0000, 1'b0, 4'b0000);
      check("hold_m_src", W'(m_src), 0);
      check("hold_m_data", m_data, dat(0, 2));
    end
    cyc(4'b1111, 4'b0000, 1'b1, 4'b0010);
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000);
    push(2); push(2); push(2); push(3);
    cyc(4'b1111, 4'b0100, 1'b1, 4'b0100);
    cyc(4'b1111, 4'b0100, 1'b1, 4'b0100);
    cyc(4'b1111, 4'b0000, 1'b1, 4'b0100);
    cyc(4'b1111, 4'b0000, 1'b1, 4'b1000);
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000);
    for (int k = 0; k < 8; k++) push(1);
    push(2); push(3); push(1); push(1);
    for (int k = 0; k < 8; k++) cyc(4'b1110, 4'b0010, 1'b1, 4'b0010);
    cyc(4'b1110, 4'b0010, 1'b1, 4'b0100);
    cyc(4'b1110, 4'b0010, 1'b1, 4'b1000);
    cyc(4'b1110, 4'b0010, 1'b1, 4'b0010);
    cyc(4'b0010, 4'b0000, 1'b1, 4'b0010);
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000);
    for (int k = 0; k < 8; k++) push(0);
    push(1);
    cyc(4'b0001, 4'b0001, 1'b1, 4'b0001);
    cyc(4'b0011, 4'b0001, 1'b1, 4'b0001);
    for (int k = 0; k < 3; k++) cyc(4'b0010, 4'b0001, 1'b1, 4'b0000);
    for (int k = 0; k < 6; k++) cyc(4'b0011, 4'b0001, 1'b1, 4'b0001);
    cyc(4'b0011, 4'b0001, 1'b1, 4'b0010);
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000);
    cyc(4'b1000, 4'b1000, 1'b1, 4'b1000);
    cyc(4'b1000, 4'b1000, 1'b0, 4'b0000);
    drive(4'b1111, 4'b0000, 1'b1);
    rst = 1'b0;
    #1;
    check("midrst_m_valid", W'(m_valid), 0);
    check("midrst_s_ready", W'(s_ready), 0);
    check("midrst_m_data", m_data, 0);
    check("midrst_m_src", W'(m_src), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    push(0);
    cyc(4'b1111, 4'b0000, 1'b1, 4'b0001);
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    check("queue_left", W'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mygo_chan_arb.md
# mygo_chan_arb

N-way round-robin arbiter that merges several producer handshake streams onto the single input port of a `mygo_fifo`. It models multiple goroutines sending on one channel. It sits between the sender-side logic the backend emits and the channel FIFO's `in_*` port. A per-sender lock lets one sender own the channel for a bounded burst. A one-entry output register decouples the arbitration decision from FIFO backpressure.

## Interface
- `WIDTH`, 32, payload width in bits.
- `N`, 4, number of senders; legal range 2..16.
- `MAX_BURST`, 8, maximum consecutive beats one sender may hold a lock for; 1 disables locking.
- `IDX_BITS`, `$clog2(N)`, width of sender indices (derived; do not override).
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `s_data` input N*WIDTH: sender payloads; sender i occupies bits [i*WIDTH +: WIDTH].
- `s_valid` input N: sender i offers a beat.
- `s_lock` input N: qualifies sender i's beat; 1 means keep the grant after this beat.
- `s_ready` output N: sender i's beat is accepted this cycle.
- `m_data` output WIDTH: registered payload toward the FIFO `in_data`.
- `m_valid` output 1: output register holds a beat; drives FIFO `in_valid`.
- `m_ready` input 1: FIFO `in_ready`.
- `m_src` output IDX_BITS: sender index of the beat in `m_data`.

## Operation
- **Output register.**
  - `accept = !m_valid | m_ready`.
  - On an accepted sender beat, the register loads `s_data` slice, `m_src`, and sets `m_valid`.
  - On drain with no new beat, `m_valid` clears; `m_data`/`m_src` hold.
- **Winner selection.** At most one `s_ready` bit is high. `s_ready[w] = accept & s_valid[w]` for the current winner w; all other bits are 0.
- **Combinational path.** `s_ready` may depend combinationally on `s_valid` and `m_ready`. Senders must not make `s_valid` depend on `s_ready`.
- **ARB_IDLE state.**
  - The winner is the first asserted `s_valid` searching from `last+1` modulo N.
  - On acceptance, `last` updates to w.
  - If `s_lock[w]=1` and `MAX_BURST>1`, go to ARB_LOCKED with `owner=w` and `burst=1`.
- **ARB_LOCKED state.**
  - Only `owner` can win; other senders see `s_ready=0` even when the owner is idle.
  - Each accepted owner beat increments `burst`.
  - Return to ARB_IDLE after an accepted owner beat with `s_lock=0`, or when that beat makes `burst==MAX_BURST`.
  - The owner dropping `s_valid` does not release the lock; the channel stalls until the owner sends again.
- **Counter width.** `burst` is `$clog2(MAX_BURST+1)` bits and never exceeds `MAX_BURST`.
- **Rotation.** After a locked burst releases, the next search starts at `owner+1`.

## Timing
- **Reset values.** While `rst` is low:
  - `m_valid=0`, `m_data=0`, `m_src=0`, `s_ready=0`.
  - state = ARB_IDLE, `burst=0`, `last=N-1`, so sender 0 has first priority.
- **Reset release.** Arbitration resumes on the first rising edge after `rst` deasserts.
- **Latency and throughput.**
  - A beat accepted in cycle t is presented on `m_*` in cycle t+1.
  - Sustained throughput is 1 beat/cycle when `m_ready` is held 1.
- **Full downstream.** With `m_valid=1` and `m_ready=0`:
  - `s_ready` is all 0.
  - State, `last` and `burst` hold.
  - `m_data`/`m_src` stay stable until drained.
- **Simultaneous drain and load.** The register reloads in the same edge; no bubble.
- **Reset mid-operation.** Any pending beat in the output register is discarded, and any lock and burst count are cleared.

## Structure
- **Shared package `mygo_arb_pkg`:**
  - `typedef enum logic [0:0] {ARB_IDLE, ARB_LOCKED} arb_state_t`.
  - Constant `ARB_MAX_SENDERS = 16`.
- **Sub-module `mygo_rr_pick`** (combinational, parameter N):
  - Inputs: request vector and `last` index.
  - Outputs: `any` and winner index.
  - Reused by future multi-port channel select logic.

## Test plan
- **Reset.** Assert `rst=0` mid-burst while `m_valid=1` -> `m_valid=0` and `s_ready=0` during reset. After release, all four senders valid makes sender 0 win first.
- **Fair rotation.** N=4; all `s_valid=1`, `s_lock=0`, `m_ready=1` for 8 cycles -> `m_src` sequence 0,1,2,3,0,1,2,3 starting one cycle after the first accept, with payloads matching.
- **Backpressure.** Hold `m_ready=0` for 5 cycles with `m_valid=1` -> `s_ready=0`; `m_data`/`m_src` unchanged. Releasing `m_ready` gives the next beat the following cycle with no bubble.
- **Lock with voluntary release.**
  - Sender 2 sends 3 beats with `s_lock`=1,1,0 while the others request.
  - Expected: 3 consecutive `m_src=2`, then sender 3 wins.
- **Burst cap.** `MAX_BURST=8`, sender 1 holds `s_lock=1` continuously -> exactly 8 consecutive beats from 1, then sender 2 wins and sender 1 may re-lock later.
- **Owner gap.** Locked owner 0 drops `s_valid` for 3 cycles while sender 1 is valid -> `s_ready[1]` stays 0. Owner resumes and still owns the channel; `burst` continues from its prior count.
